rsa_modexp_engine: RTL
======================

// Module: rsa_modexp_engine
// PURPOSE
//   Self-contained parametrised modular-exponentiation engine: c = m^e mod n, WIDTH-bit operands.
//   Successor to the fixed-256-bit RSA encrypt stage; serves both encrypt (e) and decrypt (d).
//   Contains its own bit-serial interleaved modular multiplier and valid/ready handshakes on both sides.
//   Adds optional constant-time exponent scan, operand checking, abort and output back-pressure.
// PARAMETERS
//   WIDTH       256  operand width in bits (m, e, n, c); minimum 4
//   CONST_TIME  0    1 = multiply on every exponent bit (dummy result discarded when bit=0)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset (asserted when 0)
//   in_valid   in   1      operand set presented
//   in_ready   out  1      engine can accept operands (high only in IDLE)
//   in_m       in   WIDTH  message/ciphertext base
//   in_e       in   WIDTH  exponent (public e or private d)
//   in_n       in   WIDTH  modulus
//   abort      in   1      synchronous cancel of the current job
//   out_valid  out  1      result available
//   out_ready  in   1      downstream accepts result
//   out_c      out  WIDTH  result m^e mod n (0 when out_err)
//   out_err    out  1      operand error for this result
//   busy       out  1      high in any state other than IDLE
// BEHAVIOUR
//   Reset (reset=0, any time, incl. mid-job): state=IDLE, all operand/accumulator regs 0,
//     in_ready=1 once reset deasserts, out_valid=0, out_c=0, out_err=0, busy=0. Job is lost.
//   Accept: in_valid & in_ready at an edge latches m,e,n; next state CHECK.
//   FSM: IDLE -> CHECK -> {SQR <-> MUL}* -> DONE -> IDLE.
//   CHECK (1 cycle): if n<2 or m>=n -> DONE with out_err=1, out_c=0; else R=1, bit index i=WIDTH-1, -> SQR.
//   SQR (WIDTH cycles): R = R*R mod n.
//   MUL (WIDTH cycles): entered after SQR if e[i]=1 (R = R*m mod n) or CONST_TIME=1 and e[i]=0
//     (D = R*m mod n computed, discarded; R unchanged). Skipped when e[i]=0 and CONST_TIME=0.
//   After bit i: if i==0 -> DONE else i=i-1 -> SQR. All WIDTH exponent bits always scanned (leading zeros incl.).
//   Modular multiply a*b mod n, interleaved, MSB-first, one bit of b per cycle:
//     P=0; per step j=WIDTH-1..0: P=2P, if P>=n P-=n; if b[j] P+=a, if P>=n P-=n.
//     Internal datapath WIDTH+1 bits; P<n invariant holds every cycle; no overflow permitted.
//   Latency accept edge -> out_valid high: 2 + WIDTH*(WIDTH+k) cycles, k = number of MUL phases
//     (k = popcount(e) if CONST_TIME=0, k = WIDTH if CONST_TIME=1). Error path: 2 cycles.
//   DONE: out_valid=1, out_c/out_err stable until out_valid & out_ready edge -> IDLE, out_valid=0.
//     out_c/out_err keep last value after handshake until next result. in_ready=0 while in DONE.
//   e=0 -> out_c=1. m=0 -> out_c=0 (e>0) or 1 (e=0).
//   abort=1 in CHECK/SQR/MUL: next edge -> IDLE, no out_valid; abort ignored in IDLE and DONE.
//   in_valid while busy is ignored (not queued); operands may change freely after accept.
// TESTING (bench uses WIDTH=8 unless noted)
//   1. m=4,e=3,n=33,CONST_TIME=0 -> out_c=31, out_err=0, out_valid exactly 82 cycles after accept.
//   2. Same with CONST_TIME=1 -> out_c=31, latency exactly 130; then m=31,e=7,n=33 -> out_c=4.
//   3. n=1 -> out_err=1,out_c=0 at 2 cycles; m=40,n=33 -> out_err=1; e=0,m=5,n=33 -> out_c=1.
//   4. Hold out_ready=0 for 50 cycles after result -> out_valid/out_c stable, in_ready=0; release -> IDLE.
//   5. reset=0 mid-SQR and abort mid-MUL -> no out_valid, back to IDLE; next job m=4,e=13,n=77 -> 53.
//   6. WIDTH=256 random odd n, m<n, e=65537 vs reference model, 20 vectors -> all match.

Source files
------------

// File: rtl/rsa_modexp_engine.sv
// rtl/rsa_modexp_engine.sv - square-and-multiply modular exponentiation with bit-serial interleaved multiplier
module rsa_modexp_engine #(
  parameter int WIDTH      = 256,
  parameter bit CONST_TIME = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_m,
  input  logic [WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0] in_n,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_err,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SQR,
    S_MUL,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] e_r;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH:0]   p;
  logic [IW-1:0]    bit_idx;
  logic [IW-1:0]    step_idx;

  logic             op_err;
  logic             last_step;
  logic             last_bit;
  logic             cur_bit;
  logic             mul_needed;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH:0]   n_ext;
  logic [WIDTH:0]   dbl;
  logic [WIDTH:0]   dbl_red;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH:0]   p_next;

  // One interleaved multiply step: P = 2P mod n, then add a if the current bit of b is set, mod n.
  // P < n on entry, so 2P and P+a both stay below 2n and fit in WIDTH+1 bits.
  always_comb begin
    n_ext      = {1'b0, n_r};
    mul_a      = r_acc;
    mul_b      = (state == S_MUL) ? m_r : r_acc;
    dbl        = p << 1;
    dbl_red    = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
    acc_sum    = mul_b[step_idx] ? (dbl_red + {1'b0, mul_a}) : dbl_red;
    p_next     = (acc_sum >= n_ext) ? (acc_sum - n_ext) : acc_sum;
    op_err     = (n_r < WIDTH'(2)) || (m_r >= n_r);
    last_step  = (step_idx == '0);
    last_bit   = (bit_idx == '0);
    cur_bit    = e_r[bit_idx];
    mul_needed = cur_bit | CONST_TIME;
  end

  // Next-state: IDLE -> CHECK -> {SQR <-> MUL}* -> DONE -> IDLE, abort returns to IDLE from working states.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_CHECK;
      S_CHECK: begin
        if (abort)       state_nx = S_IDLE;
        else if (op_err) state_nx = S_DONE;
        else             state_nx = S_SQR;
      end
      S_SQR: begin
        if (abort) state_nx = S_IDLE;
        else if (last_step) begin
          if (mul_needed)    state_nx = S_MUL;
          else if (last_bit) state_nx = S_DONE;
          else               state_nx = S_SQR;
        end
      end
      S_MUL: begin
        if (abort) state_nx = S_IDLE;
        else if (last_step) state_nx = last_bit ? S_DONE : S_SQR;
      end
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Operand capture, accumulator update per phase, and result registers written on entry to DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_r      <= '0;
      e_r      <= '0;
      n_r      <= '0;
      r_acc    <= '0;
      p        <= '0;
      bit_idx  <= '0;
      step_idx <= '0;
      out_c    <= '0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            m_r <= in_m;
            e_r <= in_e;
            n_r <= in_n;
          end
        end
        S_CHECK: begin
          r_acc    <= WIDTH'(1);
          bit_idx  <= IW'(WIDTH - 1);
          step_idx <= IW'(WIDTH - 1);
          p        <= '0;
          if (op_err && !abort) begin
            out_c   <= '0;
            out_err <= 1'b1;
          end
        end
        S_SQR, S_MUL: begin
          if (!last_step) begin
            p        <= p_next;
            step_idx <= step_idx - 1'b1;
          end else begin
            p        <= '0;
            step_idx <= IW'(WIDTH - 1);
            if (state == S_SQR) begin
              r_acc <= p_next[WIDTH-1:0];
              if (!mul_needed) begin
                if (!last_bit) bit_idx <= bit_idx - 1'b1;
                else if (!abort) begin
                  out_c   <= p_next[WIDTH-1:0];
                  out_err <= 1'b0;
                end
              end
            end else begin
              // With a zero exponent bit the product is a dummy and R is kept.
              if (cur_bit) r_acc <= p_next[WIDTH-1:0];
              if (!last_bit) bit_idx <= bit_idx - 1'b1;
              else if (!abort) begin
                out_c   <= cur_bit ? p_next[WIDTH-1:0] : r_acc;
                out_err <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule
